// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_pkg : shared constants and state encodings for the UART tx scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_tx_pkg;

  localparam logic [7:0]  SYNC_BYTE      = 8'hAA;
  localparam logic [7:0]  TAG_NONCE      = 8'h01;
  localparam logic [7:0]  TAG_STATUS     = 8'h02;
  localparam int unsigned BUSY_TIMEOUT   = 16;
  localparam int unsigned TIMEOUT_W      = $clog2(BUSY_TIMEOUT);
  localparam int unsigned FRAME_LEN_BASE = 6;
  localparam int unsigned FRAME_LEN_CSUM = 7;

  typedef enum logic [1:0] {
    FRAME_IDLE,
    FRAME_BYTE,
    FRAME_NEXT
  } frame_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_STROBE,
    HS_WAIT_START,
    HS_WAIT_DONE
  } hs_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_handshake.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_byte_handshake : strobes one byte into the UART and tracks its busy flag
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_byte_handshake
  import uart_tx_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic [7:0] tx_din,
  output logic       tx_wr_en,
  output logic       done,
  output logic       timeout
);

  hs_state_t            state, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= HS_IDLE;
      tx_din   <= 8'h00;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == HS_IDLE && start) begin
        tx_din <= byte_in;
      end
      if (state == HS_STROBE) begin
        wait_cnt <= '0;
      end else if (state == HS_WAIT_START) begin
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      HS_IDLE: begin
        if (start) state_next = HS_STROBE;
      end
      HS_STROBE: begin
        state_next = HS_WAIT_START;
      end
      HS_WAIT_START: begin
        if (tx_busy) begin
          state_next = HS_WAIT_DONE;
        end else if (wait_cnt == TIMEOUT_W'(BUSY_TIMEOUT - 1)) begin
          // Give up on this byte and let the frame move on.
          timeout    = 1'b1;
          done       = 1'b1;
          state_next = HS_IDLE;
        end
      end
      HS_WAIT_DONE: begin
        if (!tx_busy) begin
          done       = 1'b1;
          state_next = HS_IDLE;
        end
      end
      default: state_next = HS_IDLE;
    endcase
  end

  assign tx_wr_en = (state == HS_STROBE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_scheduler : arbitrates nonce/status words into tagged UART frames
// Optional checksum byte: define UART_TX_CHECKSUM_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        nonce_valid,
  input  logic [31:0] nonce_word,
  output logic        nonce_ready,
  input  logic        status_valid,
  input  logic [31:0] status_word,
  output logic        status_ready,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic        frame_active,
  output logic        timeout_err,
  output logic [15:0] frames_sent
);

`ifdef UART_TX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  frame_state_t state, state_next;
  logic [2:0]   byte_idx;
  logic [2:0]   fetch_idx;
  logic [7:0]   frame_tag;
  logic [31:0]  frame_word;
  logic [7:0]   hs_byte;
  logic         accept_nonce, accept_status;
  logic         hs_start, hs_done, hs_timeout;
  logic         last_byte;

  assign last_byte    = (byte_idx == LAST_IDX);
  assign frame_active = (state != FRAME_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= FRAME_IDLE;
    else       state <= state_next;
  end

  // Nonce wins a same-cycle tie; a pending status simply waits for the next IDLE.
  always_comb begin
    state_next    = state;
    accept_nonce  = 1'b0;
    accept_status = 1'b0;
    hs_start      = 1'b0;
    case (state)
      FRAME_IDLE: begin
        if (nonce_valid && nonce_ready) begin
          accept_nonce = 1'b1;
          hs_start     = 1'b1;
          state_next   = FRAME_BYTE;
        end else if (status_valid && status_ready) begin
          accept_status = 1'b1;
          hs_start      = 1'b1;
          state_next    = FRAME_BYTE;
        end
      end
      FRAME_BYTE: begin
        if (hs_done) state_next = FRAME_NEXT;
      end
      FRAME_NEXT: begin
        if (last_byte) begin
          state_next = FRAME_IDLE;
        end else begin
          hs_start   = 1'b1;
          state_next = FRAME_BYTE;
        end
      end
      default: state_next = FRAME_IDLE;
    endcase
  end

`ifdef UART_TX_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = frame_tag ^ frame_word[31:24] ^ frame_word[23:16]
                  ^ frame_word[15:8] ^ frame_word[7:0];
`endif

  // The byte handed to the handshake is the one about to be strobed.
  always_comb begin
    fetch_idx = (state == FRAME_IDLE) ? 3'd0 : byte_idx + 3'd1;
    case (fetch_idx)
      3'd1:    hs_byte = frame_tag;
      3'd2:    hs_byte = frame_word[31:24];
      3'd3:    hs_byte = frame_word[23:16];
      3'd4:    hs_byte = frame_word[15:8];
      3'd5:    hs_byte = frame_word[7:0];
`ifdef UART_TX_CHECKSUM_EN
      3'd6:    hs_byte = checksum;
`endif
      default: hs_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx     <= 3'd0;
      frame_tag    <= 8'h00;
      frame_word   <= 32'h0;
      nonce_ready  <= 1'b0;
      status_ready <= 1'b0;
      timeout_err  <= 1'b0;
      frames_sent  <= 16'h0;
    end else begin
      nonce_ready  <= (state_next == FRAME_IDLE) && !tx_busy;
      status_ready <= (state_next == FRAME_IDLE) && !tx_busy;
      if (accept_nonce) begin
        frame_tag  <= TAG_NONCE;
        frame_word <= nonce_word;
        byte_idx   <= 3'd0;
      end else if (accept_status) begin
        frame_tag  <= TAG_STATUS;
        frame_word <= status_word;
        byte_idx   <= 3'd0;
      end
      if (state == FRAME_NEXT) begin
        if (last_byte) begin
          byte_idx    <= 3'd0;
          frames_sent <= frames_sent + 16'd1;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end
      if (hs_timeout) timeout_err <= 1'b1;
    end
  end

  uart_byte_handshake u_handshake (
    .clock    (clock),
    .reset    (reset),
    .start    (hs_start),
    .byte_in  (hs_byte),
    .tx_busy  (tx_busy),
    .tx_din   (tx_din),
    .tx_wr_en (tx_wr_en),
    .done     (hs_done),
    .timeout  (hs_timeout)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler : directed bench for uart_tx_scheduler with a UART model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

`ifdef UART_TX_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce_word = 32'h0;
  logic        status_valid = 1'b0;
  logic [31:0] status_word = 32'h0;
  logic        tx_busy = 1'b0;
  logic        nonce_ready, status_ready, tx_wr_en, frame_active, timeout_err;
  logic [7:0]  tx_din;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .nonce_valid  (nonce_valid),
    .nonce_word   (nonce_word),
    .nonce_ready  (nonce_ready),
    .status_valid (status_valid),
    .status_word  (status_word),
    .status_ready (status_ready),
    .tx_din       (tx_din),
    .tx_wr_en     (tx_wr_en),
    .tx_busy      (tx_busy),
    .frame_active (frame_active),
    .timeout_err  (timeout_err),
    .frames_sent  (frames_sent)
  );

  always #10 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART model: captures strobed bytes, stays busy for 10 cycles per byte.
  int         cyc = 0;
  int         fall_cyc = -100;
  int         busy_left = 0;
  int         busy_viol = 0;
  int         gap_viol = 0;
  bit         tie0 = 1'b0;
  logic [7:0] rx_q[$];

  always @(negedge clock) begin
    cyc++;
    if (tx_wr_en) begin
      if (tx_busy) busy_viol++;
      if (cyc - fall_cyc < 2) gap_viol++;
      rx_q.push_back(tx_din);
      if (!tie0) begin
        tx_busy   = 1'b1;
        busy_left = 10;
      end
    end else if (tx_busy) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy  = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget);
    int n = 0;
    while (frames_sent !== target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("frames_sent", {16'h0, frames_sent}, {16'h0, target});
  endtask

  task automatic check_frame(input string name, input logic [7:0] tag, input logic [31:0] w,
                             input logic [7:0] csum, input int base);
    logic [7:0]  exp [7];
    logic [31:0] got;
    exp[0] = 8'hAA;       exp[1] = tag;
    exp[2] = w[31:24];    exp[3] = w[23:16];
    exp[4] = w[15:8];     exp[5] = w[7:0];
    exp[6] = csum;
    for (int i = 0; i < FLEN; i++) begin
      got = (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hFFFF_FFFF;
      check(name, got, {24'h0, exp[i]});
    end
  endtask

  initial begin
    int n;
    int hi;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_tx_din", {24'h0, tx_din}, 32'h0);
    check("rst_wr_en", tx_wr_en, 0);
    check("rst_nonce_ready", nonce_ready, 0);
    check("rst_status_ready", status_ready, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_frames_sent", frames_sent, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", nonce_ready, 1);
    check("sready_after_rst", status_ready, 1);

    // Single nonce frame
    rx_q.delete();
    nonce_word  = 32'hDEADBEEF;
    nonce_valid = 1'b1;
    @(negedge clock);
    check("t1_strobe", tx_wr_en, 1);
    check("t1_sync", {24'h0, tx_din}, 32'hAA);
    check("t1_active", frame_active, 1);
    check("t1_ready_low", nonce_ready, 0);
    nonce_valid = 1'b0;
    nonce_word  = 32'h12345678;
    @(negedge clock);
    check("t1_strobe_width", tx_wr_en, 0);
    wait_frames(16'd1, 400);
    check("t1_len", rx_q.size(), FLEN);
    check_frame("t1_byte", 8'h01, 32'hDEADBEEF, 8'h23, 0);
    check("t1_ready_back", nonce_ready, 1);
    check("t1_idle", frame_active, 0);

    // Simultaneous nonce and status: nonce first
    rx_q.delete();
    nonce_word   = 32'h00000001;
    status_word  = 32'h00000050;
    nonce_valid  = 1'b1;
    status_valid = 1'b1;
    @(negedge clock);
    check("t2_nready_low", nonce_ready, 0);
    check("t2_sready_low", status_ready, 0);
    check("t2_sync", {24'h0, tx_din}, 32'hAA);
    nonce_valid = 1'b0;
    n = 0;
    hi = 0;
    while (frames_sent !== 16'd2 && n < 400) begin
      if (status_ready) hi++;
      @(negedge clock);
      n++;
    end
    check("t2_first_done", frames_sent, 2);
    check("t2_sready_held", hi, 0);
    check("t2_sready_idle", status_ready, 1);
    @(negedge clock);
    check("t2_status_taken", status_ready, 0);
    check("t2_status_strobe", tx_wr_en, 1);
    status_valid = 1'b0;
    wait_frames(16'd3, 400);
    check("t2_len", rx_q.size(), 2 * FLEN);
    check_frame("t2_nonce", 8'h01, 32'h00000001, 8'h00, 0);
    check_frame("t2_status", 8'h02, 32'h00000050, 8'h52, FLEN);

    // Busy never rises: timeout
    tie0 = 1'b1;
    rx_q.delete();
    nonce_word  = 32'hCAFEF00D;
    nonce_valid = 1'b1;
    @(negedge clock);
    check("t3_strobe", tx_wr_en, 1);
    nonce_valid = 1'b0;
    repeat (16) @(negedge clock);
    check("t3_err_early", timeout_err, 0);
    @(negedge clock);
    check("t3_err_set", timeout_err, 1);
    wait_frames(16'd4, 600);
    check("t3_len", rx_q.size(), FLEN);
    check_frame("t3_byte", 8'h01, 32'hCAFEF00D, 8'hC8, 0);
    check("t3_err_sticky", timeout_err, 1);
    tie0 = 1'b0;

    // Reset during WAIT_DONE of byte 3
    rx_q.delete();
    nonce_word  = 32'h0F1E2D3C;
    nonce_valid = 1'b1;
    @(negedge clock);
    nonce_valid = 1'b0;
    n = 0;
    while (rx_q.size() < 3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t4_reach_byte3", rx_q.size(), 3);
    repeat (3) @(negedge clock);
    check("t4_err_before", timeout_err, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t4_wr_en", tx_wr_en, 0);
    check("t4_idle", frame_active, 0);
    check("t4_err_clr", timeout_err, 0);
    check("t4_frames_clr", frames_sent, 0);
    repeat (12) @(negedge clock);
    check("t4_no_strobe", rx_q.size(), 3);
    check("t4_still_idle", frame_active, 0);
    n = 0;
    while (!nonce_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("t4_ready", nonce_ready, 1);
    rx_q.delete();
    nonce_word  = 32'hA5A5A5A5;
    nonce_valid = 1'b1;
    @(negedge clock);
    nonce_valid = 1'b0;
    wait_frames(16'd1, 400);
    check_frame("t4_byte", 8'h01, 32'hA5A5A5A5, 8'h01, 0);

    // Counter wrap with back-to-back status frames
    force dut.frames_sent = 16'hFFFE;
    @(negedge clock);
    release dut.frames_sent;
    @(negedge clock);
    check("t5_preset", frames_sent, 16'hFFFE);
    rx_q.delete();
    status_word  = 32'h00000050;
    status_valid = 1'b1;
    wait_frames(16'hFFFF, 400);
    status_word = 32'h01020304;
    wait_frames(16'h0000, 400);
    status_valid = 1'b0;
    check("t5_len", rx_q.size(), 2 * FLEN);
    check_frame("t5_second", 8'h02, 32'h01020304, 8'h06, FLEN);

    check("no_strobe_while_busy", busy_viol, 0);
    check("strobe_gap", gap_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
